// File: rtl/dnn_stream_host.sv
// Host-side stream mover: plays a batch from the sample RAM into the accelerator's
// src stream, then drains the accelerator's dst stream into the result RAM.
module dnn_stream_host #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_len,
  input  logic [AW-1:0] dst_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          run,
  output logic [AW-1:0] mem_ra,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rd,
  output logic          res_we,
  output logic [AW-1:0] res_wa,
  output logic [DW-1:0] res_wd,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
  input  logic          src_ready,
  input  logic          dst_valid,
  input  logic [DW-1:0] dst_data,
  input  logic          dst_last,
  output logic          dst_ready
);

  localparam logic [AW-1:0] One = 1;

  typedef enum logic [1:0] {StIdle, StSend, StRecv, StFin} state_e;

  state_e        state_q;
  logic [AW-1:0] src_len_q, dst_len_q;
  logic [AW-1:0] rd_cnt_q;   // sample RAM reads issued
  logic [AW-1:0] tx_cnt_q;   // src handshakes completed
  logic [AW-1:0] rx_cnt_q;   // dst words written

  // Skid FIFO absorbing the 1-cycle RAM read latency
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    fifo_cnt_q;
  logic          pend_q;     // read issued last cycle, data on mem_rd now

  logic          src_hs, dst_hs, rx_final;
  logic [1:0]    occ;

  // Stream, RAM-port and handshake decode
  always_comb begin
    src_valid = (fifo_cnt_q != 2'd0);
    src_data  = src_valid ? fifo_q[rd_ptr_q] : '0;
    src_last  = src_valid && ((tx_cnt_q + One) == src_len_q);
    src_hs    = src_valid & src_ready;
    // Count the word leaving this cycle so the pipe sustains one word per cycle
    occ       = fifo_cnt_q + {1'b0, pend_q} - {1'b0, src_hs};
    mem_re    = (state_q == StSend) && (rd_cnt_q < src_len_q) && (occ < 2'd2);
    mem_ra    = mem_re ? rd_cnt_q : '0;
    dst_ready = (state_q == StRecv);
    dst_hs    = dst_valid & dst_ready;
    rx_final  = ((rx_cnt_q + One) == dst_len_q);
    res_we    = dst_hs;
    res_wa    = dst_hs ? rx_cnt_q : '0;
    res_wd    = dst_hs ? dst_data : '0;
  end

  // Skid FIFO: push returning read data, pop on src handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      pend_q     <= 1'b0;
    end else begin
      pend_q <= mem_re;
      if (pend_q) begin
        fifo_q[wr_ptr_q] <= mem_rd;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (src_hs) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, src_hs};
    end
  end

  // Batch FSM with registered status outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      src_len_q <= '0;
      dst_len_q <= '0;
      rd_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      run       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_len_q <= src_len;
            dst_len_q <= dst_len;
            rd_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            busy      <= 1'b1;
            if (src_len == '0 || dst_len == '0) begin
              // Nothing to move: report and finish without enabling the accelerator
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= StFin;
            end else begin
              err     <= 1'b0;
              run     <= 1'b1;
              state_q <= StSend;
            end
          end
        end
        StSend: begin
          if (mem_re) rd_cnt_q <= rd_cnt_q + One;
          if (src_hs) begin
            tx_cnt_q <= tx_cnt_q + One;
            if (src_last) state_q <= StRecv;
          end
        end
        StRecv: begin
          if (dst_hs) begin
            rx_cnt_q <= rx_cnt_q + One;
            if (rx_final || dst_last) begin
              state_q <= StFin;
              done    <= 1'b1;
              if (dst_last != rx_final) err <= 1'b1;
            end
          end
        end
        StFin: begin
          run     <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_stream_host.sv
// Scoreboard bench for dnn_stream_host: stimulus pushes expectations, a negedge monitor
// pops and compares whenever the DUT presents a src handshake, a result write or done.
module tb_dnn_stream_host;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_len = '0, dst_len = '0;
  logic          busy, done, err, run;
  logic [AW-1:0] mem_ra;
  logic          mem_re;
  logic [DW-1:0] mem_rd = '0;
  logic          res_we;
  logic [AW-1:0] res_wa;
  logic [DW-1:0] res_wd;
  logic          src_valid, src_last;
  logic [DW-1:0] src_data;
  logic          src_ready = 1'b0;
  logic          dst_valid = 1'b0;
  logic [DW-1:0] dst_data = '0;
  logic          dst_last = 1'b0;
  logic          dst_ready;

  dnn_stream_host #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .src_len(src_len), .dst_len(dst_len),
    .busy(busy), .done(done), .err(err), .run(run),
    .mem_ra(mem_ra), .mem_re(mem_re), .mem_rd(mem_rd),
    .res_we(res_we), .res_wa(res_wa), .res_wd(res_wd),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [AW-1:0] reads;
    logic          active;  // run and src_valid expected to appear
  } done_exp_t;

  logic [DW:0]    exp_src[$];
  logic [AW+DW-1:0] exp_res[$];
  done_exp_t      exp_done[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0;
  int reads = 0, hs_n = 0, prev_cyc = 0;
  bit run_seen = 0, sv_seen = 0, b2b = 0;
  bit stall_prev = 0;
  logic [DW-1:0] stall_data = '0;
  int rdy_mode = 0, pidx = 0;
  logic [3:0] pat = 4'b1001;  // src_ready sequence 1,0,0,1 from bit 0
  logic [DW-1:0] sram [4096];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Sample RAM model: one cycle read latency
  always @(posedge clk) if (mem_re) mem_rd <= sram[mem_ra];

  // Accelerator-side src_ready pattern
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: src_ready = 1'b1;
      1: begin src_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
      default: src_ready = 1'b0;
    endcase
  end

  // Monitor
  always @(negedge clk) begin
    logic [DW:0] es;
    logic [AW+DW-1:0] er;
    done_exp_t ed;
    if (!rst) begin
      if (run) run_seen = 1;
      if (src_valid) sv_seen = 1;
      if (mem_re) reads++;
      if (stall_prev) begin
        check("stall_valid", {63'd0, src_valid}, 64'd1);
        check("stall_data", {32'd0, src_data}, {32'd0, stall_data});
      end
      stall_prev = src_valid && !src_ready;
      stall_data = src_data;
      if (src_valid && src_ready) begin
        if (exp_src.size() == 0) check("src_unexpected", 64'd1, 64'd0);
        else begin
          es = exp_src.pop_front();
          check("src_data", {32'd0, src_data}, {32'd0, es[DW-1:0]});
          check("src_last", {63'd0, src_last}, {63'd0, es[DW]});
        end
        if (b2b && hs_n > 0) check("src_b2b", 64'(cyc - prev_cyc), 64'd1);
        prev_cyc = cyc;
        hs_n++;
      end
      if (res_we) begin
        if (exp_res.size() == 0) check("res_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_res.pop_front();
          check("res_wa", {52'd0, res_wa}, {52'd0, er[AW+DW-1:DW]});
          check("res_wd", {32'd0, res_wd}, {32'd0, er[DW-1:0]});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else begin
          ed = exp_done.pop_front();
          check("done_err", {63'd0, err}, {63'd0, ed.err});
          check("done_reads", 64'(reads), {52'd0, ed.reads});
          check("done_run_seen", {63'd0, run_seen}, {63'd0, ed.active});
          check("done_sv_seen", {63'd0, sv_seen}, {63'd0, ed.active});
          check("done_src_left", 64'(exp_src.size()), 64'd0);
          check("done_res_left", 64'(exp_res.size()), 64'd0);
        end
        reads = 0; run_seen = 0; sv_seen = 0; hs_n = 0;
        done_cnt++;
      end
    end else begin
      stall_prev = 0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {55'd0, busy, done, err, run, mem_re, src_valid, src_last,
                           dst_ready, res_we}, 64'd0);
    check({tag, "_addr"}, {40'd0, mem_ra, res_wa}, 64'd0);
    check({tag, "_data"}, {src_data, res_wd}, 64'd0);
  endtask

  task automatic pulse_start(input int slen, input int dlen);
    @(posedge clk); #1;
    src_len = AW'(slen); dst_len = AW'(dlen); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One batch: nw dst words driven, dst_last on index last_idx (-1: never)
  task automatic run_batch(input int slen, input int dlen, input int base, input int nw,
                           input int last_idx, input bit exp_err, input bit chk_b2b);
    done_exp_t ed;
    int d0;
    b2b = chk_b2b;
    for (int i = 0; i < slen; i++) begin
      sram[i] = DW'(base + i);
      exp_src.push_back({i == slen - 1, DW'(base + i)});
    end
    for (int k = 0; k < nw; k++) exp_res.push_back({AW'(k), DW'(32'hD000_0000 + base + k)});
    ed.err = exp_err; ed.reads = AW'(slen); ed.active = (slen != 0 && dlen != 0);
    exp_done.push_back(ed);
    d0 = done_cnt;
    pulse_start(slen, dlen);
    if (slen == 0 || dlen == 0) begin
      check("zero_len_done_lat", {63'd0, done}, 64'd1);
    end else begin
      // Present the first dst word during SEND; it must wait for RECV
      dst_valid = 1'b1; dst_data = 32'hD000_0000 + base; dst_last = (last_idx == 0);
      for (int c = 0; c < 300 && !dst_ready; c++) begin @(posedge clk); #1; end
      check("recv_reached", {63'd0, dst_ready}, 64'd1);
      for (int k = 0; k < nw; k++) begin
        dst_data = DW'(32'hD000_0000 + base + k);
        dst_last = (k == last_idx);
        @(posedge clk); #1;
      end
      dst_valid = 1'b0; dst_last = 1'b0; dst_data = '0;
    end
    for (int c = 0; c < 100 && done_cnt == d0; c++) begin @(posedge clk); #1; end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // 1) basic batch, back-to-back src words
    rdy_mode = 0;
    run_batch(4, 2, 32'h100, 2, 1, 1'b0, 1'b1);
    // 2) src_ready stalls
    rdy_mode = 1; pidx = 0;
    run_batch(6, 2, 32'h200, 2, 1, 1'b0, 1'b0);
    rdy_mode = 0;
    // 3) early dst_last on word 2 of 3
    run_batch(3, 3, 32'h300, 2, 1, 1'b1, 1'b1);
    // 4) missing dst_last, then a clean batch clears err
    run_batch(2, 2, 32'h400, 2, -1, 1'b1, 1'b1);
    run_batch(3, 1, 32'h500, 1, 0, 1'b0, 1'b1);
    // 5) zero-length start
    run_batch(0, 2, 32'h600, 0, -1, 1'b1, 1'b0);

    // 6) reset mid-SEND with src_valid held by stalled accelerator
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) sram[i] = DW'(32'h700 + i);
    d0 = done_cnt;
    pulse_start(8, 2);
    for (int c = 0; c < 50 && !src_valid; c++) begin @(posedge clk); #1; end
    check("rst_pre_valid", {63'd0, src_valid}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    rst = 1'b0;
    reads = 0; run_seen = 0; sv_seen = 0; hs_n = 0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    rdy_mode = 0;
    run_batch(5, 3, 32'h800, 3, 2, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
